// File: rtl/hex_pkg.sv
// Shared types, segment table and round-robin search for the HEX display arbiter.
package hex_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    MANUAL = 2'd2
  } state_t;

  // Active-low segments {g,f,e,d,c,b,a} for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Lowest-numbered requester at or above from+1 (mod 4). Returns 'from'
  // when nothing but 'from' (or nothing at all) is requesting; callers
  // qualify the result with their own any-request test.
  function automatic logic [1:0] rr_next(input logic [3:0] req_vec,
                                         input logic [1:0] from);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = from;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = 4; k >= 1; k--) begin
      idx = from + 2'(k);
      if (req_vec[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/hex_display_arbiter_seg7_decode.sv
// One hex nibble to active-low 7-segment pattern, pure table lookup.
module seg7_decode
  import hex_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern
  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter with dwell time and manual override that shares the
// four-digit HEX display between four 16-bit debug values.
module hex_display_arbiter
  import hex_pkg::*;
#(
  parameter int unsigned DWELL = 25_000_000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  input  logic [15:0] val3,
  input  logic        hold,
  input  logic        manual_en,
  input  logic [1:0]  manual_sel,
  output logic [1:0]  owner,
  output logic        owner_valid,
  output logic        switch_pulse,
  output logic [15:0] disp_val,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0
);

  localparam logic [31:0] DWELL_MAX = DWELL - 32'd1;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pulse_q, pulse_d;
  logic [15:0] disp_p1, disp_d;
  logic [15:0] val_sel;
  logic [3:0]  others;
  logic [6:0]  seg3, seg2, seg1, seg0;

  // Dwell counter increment that parks at DWELL-1.
  function automatic logic [31:0] dwell_sat_inc(input logic [31:0] c);
    return (c >= DWELL_MAX) ? DWELL_MAX : c + 32'd1;
  endfunction

  // State register: arbitration state, owner bookkeeping and display stage
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
      pulse_q <= 1'b0;
      disp_p1 <= 16'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      disp_p1 <= disp_d;
    end
  end

  // Requesters other than the current owner that could take over.
  assign others = req & ~(4'b0001 << owner_q);

  // Next-state: override first, then drop, dwell rotation or idle grant
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (manual_en) begin
      state_d = MANUAL;
      owner_d = manual_sel;
      last_d  = manual_sel;
      valid_d = 1'b1;
      cnt_d   = 32'd0;
    end else begin
      case (state_q)
        MANUAL: begin
          // Leaving override always passes through IDLE for one cycle.
          state_d = IDLE;
          valid_d = 1'b0;
        end
        IDLE: begin
          if (|req) begin
            state_d = SHOW;
            owner_d = rr_next(req, last_q);
            last_d  = owner_d;
            valid_d = 1'b1;
            cnt_d   = 32'd0;
          end
        end
        SHOW: begin
          if (!req[owner_q]) begin
            // Owner gave up the display: hand over at once, dwell ignored.
            if (|req) begin
              owner_d = rr_next(req, owner_q);
              last_d  = owner_d;
              cnt_d   = 32'd0;
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
            end
          end else if (cnt_q == DWELL_MAX && !hold && |others) begin
            owner_d = rr_next(others, owner_q);
            last_d  = owner_d;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = dwell_sat_inc(cnt_q);
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // Live value of the current owner
  always_comb begin
    case (owner_q)
      2'd0:    val_sel = val0;
      2'd1:    val_sel = val1;
      2'd2:    val_sel = val2;
      default: val_sel = val3;
    endcase
  end

  // Output logic: switch pulse and display value for the next cycle
  always_comb begin
    pulse_d = valid_d && (!valid_q || (owner_d != owner_q));
    disp_d  = (valid_q && valid_d) ? val_sel : 16'd0;
  end

  assign owner        = owner_q;
  assign owner_valid  = valid_q;
  assign switch_pulse = pulse_q;
  assign disp_val     = disp_p1;

  seg7_decode u_dec3 (.nibble(disp_p1[15:12]), .seg(seg3));
  seg7_decode u_dec2 (.nibble(disp_p1[11:8]),  .seg(seg2));
  seg7_decode u_dec1 (.nibble(disp_p1[7:4]),   .seg(seg1));
  seg7_decode u_dec0 (.nibble(disp_p1[3:0]),   .seg(seg0));

  // Blank every digit while nobody owns the display
  always_comb begin
    hex3 = valid_q ? seg3 : SEG_BLANK;
    hex2 = valid_q ? seg2 : SEG_BLANK;
    hex1 = valid_q ? seg1 : SEG_BLANK;
    hex0 = valid_q ? seg0 : SEG_BLANK;
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter: table vectors, directed corner sequences and
// randomized traffic against a behavioural model, on DWELL=4 and DWELL=1 copies.
module tb_hex_display_arbiter;

  localparam logic [6:0] SEGS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [15:0] val0 = 16'd0, val1 = 16'd0, val2 = 16'd0, val3 = 16'd0;
  logic        hold = 1'b0;
  logic        manual_en = 1'b0;
  logic [1:0]  manual_sel = 2'd0;

  logic [1:0]  a_owner, b_owner;
  logic        a_valid, b_valid, a_pulse, b_pulse;
  logic [15:0] a_disp, b_disp;
  logic [6:0]  a_hex3, a_hex2, a_hex1, a_hex0;
  logic [6:0]  b_hex3, b_hex2, b_hex1, b_hex0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hex_display_arbiter #(.DWELL(4)) u_dut4 (
    .clock(clock), .resetn(resetn), .req(req),
    .val0(val0), .val1(val1), .val2(val2), .val3(val3),
    .hold(hold), .manual_en(manual_en), .manual_sel(manual_sel),
    .owner(a_owner), .owner_valid(a_valid), .switch_pulse(a_pulse),
    .disp_val(a_disp), .hex3(a_hex3), .hex2(a_hex2), .hex1(a_hex1), .hex0(a_hex0)
  );

  hex_display_arbiter #(.DWELL(1)) u_dut1 (
    .clock(clock), .resetn(resetn), .req(req),
    .val0(val0), .val1(val1), .val2(val2), .val3(val3),
    .hold(hold), .manual_en(manual_en), .manual_sel(manual_sel),
    .owner(b_owner), .owner_valid(b_valid), .switch_pulse(b_pulse),
    .disp_val(b_disp), .hex3(b_hex3), .hex2(b_hex2), .hex1(b_hex1), .hex0(b_hex0)
  );

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [1:0]  mode;   // 0 no owner, 1 arbitrated owner, 2 manual
    logic [1:0]  owner;
    logic        valid;
    logic [1:0]  last;
    logic [31:0] cnt;
    logic        pulse;
    logic [15:0] disp;
  } mst_t;

  localparam mst_t MRESET = '{mode: 2'd0, owner: 2'd0, valid: 1'b0, last: 2'd3,
                              cnt: 32'd0, pulse: 1'b0, disp: 16'd0};

  mst_t m4, m1;

  function automatic logic [1:0] pick(logic [3:0] r, logic [1:0] after);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (int'(after) + k) % 4;
      if (r[idx]) return 2'(idx);
    end
    return after;
  endfunction

  function automatic mst_t mnext(mst_t c, int dw, logic [3:0] r, logic h,
                                 logic me, logic [1:0] ms, logic [63:0] vals);
    mst_t n;
    logic [3:0] oth;
    n = c;
    oth = r;
    oth[c.owner] = 1'b0;
    if (me) begin
      n.mode = 2; n.owner = ms; n.valid = 1; n.last = ms; n.cnt = 0;
    end else if (c.mode == 2) begin
      n.mode = 0; n.valid = 0;
    end else if (c.mode == 0) begin
      if (r != 0) begin
        n.mode = 1; n.owner = pick(r, c.last); n.valid = 1; n.last = n.owner; n.cnt = 0;
      end
    end else begin
      if (!r[c.owner]) begin
        if (r == 0) begin
          n.mode = 0; n.valid = 0;
        end else begin
          n.owner = pick(r, c.owner); n.last = n.owner; n.cnt = 0;
        end
      end else if (c.cnt == 32'(dw - 1) && !h && oth != 0) begin
        n.owner = pick(oth, c.owner); n.last = n.owner; n.cnt = 0;
      end else if (c.cnt < 32'(dw - 1)) begin
        n.cnt = c.cnt + 1;
      end
    end
    n.pulse = n.valid && (!c.valid || n.owner != c.owner);
    n.disp  = (c.valid && n.valid) ? vals[c.owner*16 +: 16] : 16'd0;
    return n;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m4 <= MRESET;
      m1 <= MRESET;
    end else begin
      m4 <= mnext(m4, 4, req, hold, manual_en, manual_sel, {val3, val2, val1, val0});
      m1 <= mnext(m1, 1, req, hold, manual_en, manual_sel, {val3, val2, val1, val0});
    end
  end

  function automatic logic [6:0] exp_hex(logic v, logic [3:0] nib);
    return v ? SEGS[nib] : 7'h7F;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; req = 4'd0; hold = 1'b0; manual_en = 1'b0; manual_sel = 2'd0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic chk_model();
    chk("m4_valid", 32'(a_valid), 32'(m4.valid));
    if (m4.valid) chk("m4_owner", 32'(a_owner), 32'(m4.owner));
    chk("m4_pulse", 32'(a_pulse), 32'(m4.pulse));
    chk("m4_disp", 32'(a_disp), 32'(m4.disp));
    chk("m4_hex", {4'd0, a_hex3, a_hex2, a_hex1, a_hex0},
        {4'd0, exp_hex(m4.valid, m4.disp[15:12]), exp_hex(m4.valid, m4.disp[11:8]),
         exp_hex(m4.valid, m4.disp[7:4]), exp_hex(m4.valid, m4.disp[3:0])});
    chk("m1_valid", 32'(b_valid), 32'(m1.valid));
    if (m1.valid) chk("m1_owner", 32'(b_owner), 32'(m1.owner));
    chk("m1_pulse", 32'(b_pulse), 32'(m1.pulse));
    chk("m1_disp", 32'(b_disp), 32'(m1.disp));
    chk("m1_hex", {4'd0, b_hex3, b_hex2, b_hex1, b_hex0},
        {4'd0, exp_hex(m1.valid, m1.disp[15:12]), exp_hex(m1.valid, m1.disp[11:8]),
         exp_hex(m1.valid, m1.disp[7:4]), exp_hex(m1.valid, m1.disp[3:0])});
  endtask

  typedef struct {
    logic [3:0]  req;
    logic        men;
    logic [1:0]  msel;
    logic [1:0]  exp_owner;
    logic        exp_valid;
    logic        exp_pulse;
    logic        chk_disp;
    logic [15:0] exp_disp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int pulses;

    vecs[0] = '{4'b0000, 1'b1, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[1] = '{4'b0000, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0, 1'b1, 16'hBEEF};
    vecs[2] = '{4'b0000, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[3] = '{4'b0000, 1'b1, 2'd1, 2'd1, 1'b1, 1'b0, 1'b1, 16'h5A5A};
    vecs[4] = '{4'b0000, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[5] = '{4'b0100, 1'b0, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[6] = '{4'b0101, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 16'hBEEF};
    vecs[7] = '{4'b0101, 1'b1, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[8] = '{4'b0101, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[9] = '{4'b0101, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 16'h0000};

    // Reset with all requesters asking
    resetn = 1'b0; req = 4'b1111;
    tick();
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_owner", 32'(a_owner), 32'd0);
    chk("rst_pulse", 32'(a_pulse), 32'd0);
    chk("rst_disp", 32'(a_disp), 32'd0);
    chk("rst_hex", {4'd0, a_hex3, a_hex2, a_hex1, a_hex0}, {4'd0, {4{7'h7F}}});
    resetn = 1'b1;
    tick();
    chk("rst_grant_owner", 32'(a_owner), 32'd0);
    chk("rst_grant_valid", 32'(a_valid), 32'd1);
    chk("rst_grant_pulse", 32'(a_pulse), 32'd1);

    // Rotation: two requesters, DWELL=4
    do_reset();
    val0 = 16'h1234; val2 = 16'hBEEF; req = 4'b0101;
    for (int t = 1; t <= 12; t++) begin
      tick();
      chk("rot_owner", 32'(a_owner), (((t - 1) / 4) % 2 == 0) ? 32'd0 : 32'd2);
      chk("rot_pulse", 32'(a_pulse), ((t - 1) % 4 == 0) ? 32'd1 : 32'd0);
      if (t == 6) begin
        chk("rot_disp", 32'(a_disp), 32'hBEEF);
        chk("rot_hex3", 32'(a_hex3), 32'h03);
        chk("rot_hex2", 32'(a_hex2), 32'h06);
        chk("rot_hex0", 32'(a_hex0), 32'h0E);
      end
    end

    // Drop: owner 1 at dwell count 1 releases its request
    do_reset();
    req = 4'b1010;
    tick();
    chk("drop_first", 32'(a_owner), 32'd1);
    tick();
    req = 4'b1000;
    pulses = 0;
    tick();
    chk("drop_owner", 32'(a_owner), 32'd3);
    chk("drop_valid", 32'(a_valid), 32'd1);
    if (a_pulse) pulses++;
    for (int t = 0; t < 3; t++) begin
      tick();
      if (a_pulse) pulses++;
    end
    chk("drop_pulses", 32'(pulses), 32'd1);

    // Hold freezes the owner past saturation; release switches next cycle
    do_reset();
    req = 4'b0011; hold = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      chk("hold_owner", 32'(a_owner), 32'd0);
    end
    hold = 1'b0;
    tick();
    chk("hold_release_owner", 32'(a_owner), 32'd1);
    chk("hold_release_pulse", 32'(a_pulse), 32'd1);

    // Manual override table
    do_reset();
    val2 = 16'hBEEF; val1 = 16'h5A5A;
    for (int i = 0; i < 10; i++) begin
      req = vecs[i].req; manual_en = vecs[i].men; manual_sel = vecs[i].msel;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(a_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_pulse", i), 32'(a_pulse), 32'(vecs[i].exp_pulse));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_owner", i), 32'(a_owner), 32'(vecs[i].exp_owner));
      else
        chk($sformatf("vec%0d_blank", i), 32'(a_hex3 & a_hex2 & a_hex1 & a_hex0), 32'h7F);
      if (vecs[i].chk_disp)
        chk($sformatf("vec%0d_disp", i), 32'(a_disp), 32'(vecs[i].exp_disp));
    end
    manual_en = 1'b0;

    // Reset pulse while requester 2 owns the display
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    chk("mid_owner_before", 32'(a_owner), 32'd2);
    req = 4'b0101;
    resetn = 1'b0;
    #1;
    chk("mid_async_valid", 32'(a_valid), 32'd0);
    chk("mid_async_owner", 32'(a_owner), 32'd0);
    chk("mid_async_disp", 32'(a_disp), 32'd0);
    chk("mid_async_hex", {4'd0, a_hex3, a_hex2, a_hex1, a_hex0}, {4'd0, {4{7'h7F}}});
    tick();
    resetn = 1'b1;
    tick();
    chk("mid_regrant_owner", 32'(a_owner), 32'd0);
    chk("mid_regrant_valid", 32'(a_valid), 32'd1);

    // Randomized traffic against the reference model on both dwell settings
    do_reset();
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      hold = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) manual_en = ~manual_en;
      if ($urandom_range(0, 3) == 0) manual_sel = 2'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        val0 = 16'($urandom); val1 = 16'($urandom);
        val2 = 16'($urandom); val3 = 16'($urandom);
      end
      tick();
      chk_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
